// File: rtl/btn_scan_ctrl_pkg.sv
// Shared types and helpers for the scanned button controller.
package btn_pkg;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Event byte: [7] edge direction, [6:3] zero, [2:0] button index.
  function automatic logic [7:0] make_evt(input logic edge_dir, input logic [2:0] idx);
    return {edge_dir, 4'b0000, idx};
  endfunction

endpackage

// File: rtl/btn_scan_ctrl_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two register stages to settle metastability before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Round-robin debounce of N_BTN buttons sharing one hold timer,
// with level/pulse outputs and a valid/ready event byte port.
module btn_scan_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int HOLD_CYCLES = 256,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             evt_valid,
  output logic [7:0]       evt_data,
  input  logic             evt_ready
);

  localparam int PTR_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] btn_sync;

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_adv;
  logic [CNT_W-1:0] timer, timer_n;
  logic [N_BTN-1:0] level_n, press_n, release_n;
  logic             valid_n;
  logic [7:0]       data_n;
  logic [2:0]       ptr_idx;
  logic             new_lvl;

  for (genvar i = 0; i < N_BTN; i++) begin : g_sync
    sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw[i]),
      .q   (btn_sync[i])
    );
  end

  assign ptr_idx = 3'(ptr);
  assign ptr_adv = (ptr == PTR_W'(N_BTN - 1)) ? '0 : ptr + PTR_W'(1);
  assign new_lvl = ~btn_level[ptr];

  // State, pointer, timer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SCAN;
      ptr           <= '0;
      timer         <= '0;
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      evt_valid     <= 1'b0;
      evt_data      <= '0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      timer         <= timer_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      evt_valid     <= valid_n;
      evt_data      <= data_n;
    end
  end

  // Scan/hold decisions and next values for every register.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    timer_n   = timer;
    level_n   = btn_level;
    press_n   = '0;
    release_n = '0;
    valid_n   = evt_valid & ~evt_ready;
    data_n    = evt_data;
    unique case (state)
      SCAN: begin
        if (btn_sync[ptr] != btn_level[ptr]) begin
          // A pending event stalls the scan on this button rather than dropping it.
          if (!evt_valid) begin
            level_n[ptr] = new_lvl;
            if (new_lvl) press_n[ptr]   = 1'b1;
            else         release_n[ptr] = 1'b1;
            valid_n = 1'b1;
            data_n  = make_evt(new_lvl ? EVT_PRESS : EVT_RELEASE, ptr_idx);
            timer_n = '0;
            state_n = HOLD;
          end
        end else begin
          ptr_n = ptr_adv;
        end
      end
      HOLD: begin
        timer_n = timer + CNT_W'(1);
        if (timer == CNT_W'(HOLD_CYCLES - 1)) begin
          state_n = SCAN;
          ptr_n   = ptr_adv;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Bench for btn_scan_ctrl: directed scenarios plus random stimulus,
// all outputs compared every cycle against a behavioural model.
module tb_btn_scan_ctrl;

  localparam int N    = 4;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, press_pulse, release_pulse;
  logic         evt_valid;
  logic [7:0]   evt_data;
  logic         evt_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] dut_log[$];
  int         press_cyc[$];

  btn_scan_ctrl #(
    .N_BTN       (N),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_data      (evt_data),
    .evt_ready     (evt_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model: sync history, debounced levels, hold countdown,
  // one-deep pending event.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  logic         m_valid, m_take;
  logic [7:0]   m_data;
  logic [1:0]   m_ptr;
  int           m_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      m_valid = 1'b0; m_data = '0; m_ptr = '0; m_hold = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      m_take  = m_valid && evt_ready;
      if (m_hold > 0) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_ptr = 2'((int'(m_ptr) + 1) % N);
      end else if (m_s2[m_ptr] != m_level[m_ptr]) begin
        if (!m_valid) begin
          m_level[m_ptr] = m_s2[m_ptr];
          if (m_s2[m_ptr]) m_press[m_ptr] = 1'b1;
          else             m_rel[m_ptr]   = 1'b1;
          m_valid = 1'b1;
          m_data  = 8'((m_s2[m_ptr] ? 128 : 0) + int'(m_ptr));
          m_hold  = HOLD;
        end
      end else begin
        m_ptr = 2'((int'(m_ptr) + 1) % N);
      end
      if (m_take) m_valid = 1'b0;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    if (!rst && evt_valid && evt_ready) dut_log.push_back(evt_data);
    @(posedge clk);
    #1;
    cyc++;
    if (|press_pulse) press_cyc.push_back(cyc);
    chk("btn_level",     32'(btn_level),     32'(m_level));
    chk("press_pulse",   32'(press_pulse),   32'(m_press));
    chk("release_pulse", 32'(release_pulse), 32'(m_rel));
    chk("evt_valid",     32'(evt_valid),     32'(m_valid));
    chk("evt_data",      32'(evt_data),      32'(m_data));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Align so the first scan after a raw change lands on button 0.
  task automatic wait_ptr2();
    int k;
    k = 0;
    while (!(m_ptr == 2'd2 && m_hold == 0 && !m_valid) && k < 40) begin
      tick();
      k++;
    end
    chk("align_timeout", 32'(k < 40), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 32'(btn_level),     32'd0);
    chk({tag, "_press"}, 32'(press_pulse),   32'd0);
    chk({tag, "_rel"},   32'(release_pulse), 32'd0);
    chk({tag, "_valid"}, 32'(evt_valid),     32'd0);
    chk({tag, "_data"},  32'(evt_data),      32'd0);
  endtask

  initial begin
    int lat;
    int k;
    rst       = 1'b1;
    btn_raw   = '0;
    evt_ready = 1'b1;
    ticks(3);
    chk_all_zero("reset");
    #2 rst = 1'b0;

    // Idle: no events for 100 cycles.
    ticks(100);
    chk("idle_no_events", 32'(dut_log.size()), 32'd0);

    // Clean press on button 2.
    btn_raw[2] = 1'b1;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (press_pulse[2]) begin lat = i; break; end
    end
    chk("b2_press_latency_le7", 32'(lat <= 7), 32'd1);
    chk("b2_level", 32'(btn_level[2]), 32'd1);
    chk("b2_data", 32'(evt_data), 32'h82);
    tick();
    chk("b2_pulse_one_cycle", 32'(press_pulse[2]), 32'd0);
    ticks(20);
    chk("b2_event_count", 32'(dut_log.size()), 32'd1);
    chk("b2_event_byte", 32'(dut_log[0]), 32'h82);
    btn_raw[2] = 1'b0;
    ticks(30);
    dut_log.delete();

    // Bouncy press on button 1, then clean release.
    for (int b = 0; b < 4; b++) begin
      btn_raw[1] = (b % 2 == 0);
      ticks(3);
    end
    btn_raw[1] = 1'b1;
    ticks(30);
    chk("bounce_event_count", 32'(dut_log.size()), 32'd1);
    chk("bounce_press_byte", 32'(dut_log[0]), 32'h81);
    btn_raw[1] = 1'b0;
    ticks(30);
    chk("bounce_total_events", 32'(dut_log.size()), 32'd2);
    chk("bounce_release_byte", 32'(dut_log[1]), 32'h01);
    dut_log.delete();

    // Back-pressure: buttons 0 and 3 pressed while the consumer stalls.
    evt_ready = 1'b0;
    wait_ptr2();
    btn_raw = 4'b1001;
    ticks(40);
    chk("bp_valid_held", 32'(evt_valid), 32'd1);
    chk("bp_data_held", 32'(evt_data), 32'h80);
    chk("bp_none_taken", 32'(dut_log.size()), 32'd0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    ticks(40);
    chk("bp_first_taken", 32'(dut_log.size()), 32'd1);
    chk("bp_first_byte", 32'(dut_log[0]), 32'h80);
    chk("bp_second_pending", 32'(evt_data), 32'h83);
    evt_ready = 1'b1;
    ticks(5);
    chk("bp_total", 32'(dut_log.size()), 32'd2);
    chk("bp_second_byte", 32'(dut_log[1]), 32'h83);
    btn_raw = '0;
    ticks(100);
    dut_log.delete();

    // Simultaneous press of all buttons.
    wait_ptr2();
    press_cyc.delete();
    btn_raw = 4'b1111;
    ticks(100);
    chk("all_count", 32'(dut_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("all_order", 32'(dut_log[i]), 32'(8'h80 + i));
    chk("all_pulse_count", 32'(press_cyc.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("all_gap_ge_hold", 32'((press_cyc[i] - press_cyc[i-1]) >= HOLD), 32'd1);
    btn_raw = '0;
    ticks(100);
    dut_log.delete();

    // Reset in HOLD with an event pending; button 0 kept high.
    evt_ready = 1'b0;
    btn_raw[0] = 1'b1;
    k = 0;
    while (!evt_valid && k < 10) begin tick(); k++; end
    chk("mid_evt_seen", 32'(evt_valid), 32'd1);
    ticks(3);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    ticks(2);
    #2 rst = 1'b0;
    evt_ready = 1'b1;
    k = 0;
    while (dut_log.size() == 0 && k < 12) begin tick(); k++; end
    chk("post_rst_count", 32'(dut_log.size()), 32'd1);
    chk("post_rst_byte", 32'(dut_log[0]), 32'h80);

    // Random phase: sparse and bursty toggles, random ready.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) btn_raw = btn_raw ^ 4'(1 << $urandom_range(0, 3));
      evt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
